// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, UNROLL bits per cycle.
// Optional MDU_FAST_MUL_EN: multiplies complete combinationally at accept, skipping the iterative path.
module mdu_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_result,
  output logic            busy
);

  localparam int ITER = XLEN / UNROLL;
  localparam int CW   = $clog2(ITER + 1);
  localparam int W2   = 2 * XLEN;
  localparam logic [XLEN-1:0] ONES_V = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_V = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t          state_r, state_nx_s;
  logic [2:0]      op_r;
  logic            neg_r;
  logic [W2-1:0]   acc_r;
  logic [W2-1:0]   mcand_r;
  logic [XLEN-1:0] mplier_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] result_r;

  logic            accept_s, is_div_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic            special_s;
  logic [XLEN-1:0] special_res_s;
  logic            fast_mul_s;
  logic [XLEN-1:0] fast_res_s;
  logic [W2-1:0]   acc_nx_s, mcand_nx_s;
  logic [XLEN-1:0] mplier_nx_s;
  logic [XLEN-1:0] rem_v, quo_v;
  logic [XLEN:0]   tmp_v;
  logic [W2-1:0]   prod_v;
  logic [XLEN-1:0] fix_res_s;

  assign accept_s = (state_r == S_IDLE) && in_valid && !flush;

  // Operand decode: signedness, magnitudes and results resolved without iterating
  always_comb begin
    is_div_s   = mdu_op[2];
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (mdu_op)
      3'b001, 3'b100, 3'b110: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'b010:  a_signed_s = 1'b1;
      default: a_signed_s = 1'b0;
    endcase
    a_neg_s = a_signed_s & rs1[XLEN-1];
    b_neg_s = b_signed_s & rs2[XLEN-1];
    a_mag_s = a_neg_s ? -rs1 : rs1;
    b_mag_s = b_neg_s ? -rs2 : rs2;
    special_s     = 1'b0;
    special_res_s = ZERO_V;
    if (is_div_s && (rs2 == ZERO_V)) begin
      special_s     = 1'b1;
      special_res_s = mdu_op[1] ? rs1 : ONES_V;
    end else if (is_div_s && !mdu_op[0] && (rs1 == MIN_V) && (rs2 == ONES_V)) begin
      special_s     = 1'b1;
      special_res_s = mdu_op[1] ? ZERO_V : rs1;
    end else begin
      special_s     = 1'b0;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [W2-1:0] fast_prod_s, fast_sgn_s;
  assign fast_prod_s = {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s};
  assign fast_sgn_s  = (a_neg_s ^ b_neg_s) ? -fast_prod_s : fast_prod_s;
  assign fast_res_s  = (mdu_op[1:0] == 2'b00) ? fast_sgn_s[XLEN-1:0] : fast_sgn_s[W2-1:XLEN];
  assign fast_mul_s  = ~mdu_op[2];
`else
  assign fast_res_s  = ZERO_V;
  assign fast_mul_s  = 1'b0;
`endif

  // One UNROLL-bit iteration of either shift-add multiply or restoring divide
  always_comb begin
    acc_nx_s    = acc_r;
    mcand_nx_s  = mcand_r;
    mplier_nx_s = mplier_r;
    rem_v       = acc_r[W2-1:XLEN];
    quo_v       = acc_r[XLEN-1:0];
    tmp_v       = {(XLEN+1){1'b0}};
    if (op_r[2]) begin
      for (int i = 0; i < UNROLL; i++) begin
        tmp_v = {rem_v, quo_v[XLEN-1]};
        quo_v = {quo_v[XLEN-2:0], 1'b0};
        if (tmp_v >= {1'b0, mplier_r}) begin
          tmp_v    = tmp_v - {1'b0, mplier_r};
          quo_v[0] = 1'b1;
        end else begin
          quo_v[0] = 1'b0;
        end
        rem_v = tmp_v[XLEN-1:0];
      end
      acc_nx_s = {rem_v, quo_v};
    end else begin
      for (int i = 0; i < UNROLL; i++) begin
        if (mplier_nx_s[0]) begin
          acc_nx_s = acc_nx_s + mcand_nx_s;
        end else begin
          acc_nx_s = acc_nx_s;
        end
        mcand_nx_s  = {mcand_nx_s[W2-2:0], 1'b0};
        mplier_nx_s = {1'b0, mplier_nx_s[XLEN-1:1]};
      end
    end
  end

  // FIX consumes the last iteration directly from the step logic, then sign-corrects
  always_comb begin
    prod_v = neg_r ? -acc_nx_s : acc_nx_s;
    case (op_r)
      3'b000:                 fix_res_s = prod_v[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_v[W2-1:XLEN];
      3'b100, 3'b101:         fix_res_s = neg_r ? -acc_nx_s[XLEN-1:0] : acc_nx_s[XLEN-1:0];
      3'b110, 3'b111:         fix_res_s = neg_r ? -acc_nx_s[W2-1:XLEN] : acc_nx_s[W2-1:XLEN];
      default:                fix_res_s = ZERO_V;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; flush wins over every other input
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (flush) begin
          state_nx_s = S_IDLE;
        end else if (in_valid) begin
          if (special_s || fast_mul_s) begin
            state_nx_s = S_DONE;
          end else begin
            state_nx_s = (ITER == 1) ? S_FIX : S_BUSY;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_nx_s = S_IDLE;
        end else if (cnt_r == CW'(2)) begin
          state_nx_s = S_FIX;
        end else begin
          state_nx_s = S_BUSY;
        end
      end
      S_FIX:   state_nx_s = flush ? S_IDLE : S_DONE;
      S_DONE:  state_nx_s = (flush || out_ready) ? S_IDLE : S_DONE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Datapath registers: latch at accept, iterate in BUSY, capture result in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 3'b000;
      neg_r    <= 1'b0;
      acc_r    <= {W2{1'b0}};
      mcand_r  <= {W2{1'b0}};
      mplier_r <= ZERO_V;
      cnt_r    <= {CW{1'b0}};
      result_r <= ZERO_V;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r     <= mdu_op;
            neg_r    <= (is_div_s && mdu_op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
            acc_r    <= is_div_s ? {ZERO_V, a_mag_s} : {W2{1'b0}};
            mcand_r  <= {ZERO_V, a_mag_s};
            mplier_r <= b_mag_s;
            cnt_r    <= CW'(ITER);
            if (special_s) begin
              result_r <= special_res_s;
            end else if (fast_mul_s) begin
              result_r <= fast_res_s;
            end
          end
        end
        S_BUSY: begin
          if (!flush) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= mcand_nx_s;
            mplier_r <= mplier_nx_s;
            cnt_r    <= cnt_r - CW'(1);
          end
        end
        S_FIX: begin
          if (!flush) begin
            result_r <= fix_res_s;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == S_IDLE);
  assign out_valid  = (state_r == S_DONE);
  assign busy       = (state_r == S_BUSY) || (state_r == S_FIX);
  assign mdu_result = result_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: XLEN=32 directed vectors plus an XLEN=16/UNROLL=4 sweep against a reference.
module tb_mdu_iter;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL32 = 1;
  localparam bit FASTM = 1'b1;
`else
  localparam int MUL32 = 33;
  localparam bit FASTM = 1'b0;
`endif
  localparam int DIV32 = 33;

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  mdu_op;
  logic [31:0] rs1, rs2, mdu_result;

  logic        h_in_valid, h_in_ready, h_flush, h_out_valid, h_out_ready, h_busy;
  logic [2:0]  h_op;
  logic [15:0] h_rs1, h_rs2, h_result;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mdu_op(mdu_op),
    .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .mdu_result(mdu_result), .busy(busy));

  mdu_iter #(.XLEN(16), .UNROLL(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .mdu_op(h_op),
    .rs1(h_rs1), .rs2(h_rs2), .flush(h_flush), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .mdu_result(h_result), .busy(h_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns edges from accept until out_valid
  task automatic wait_done32(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b1; mdu_op = op; rs1 = a; rs2 = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; mdu_op = 3'($urandom);
    wait_done32(n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, {32'h0, mdu_result}, {32'h0, exp});
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] ref16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    ovf = (a == 16'h8000) && (b == 16'hFFFF);
    p = 64'sd0;
    case (op)
      3'd0: begin p = ua * ub; return p[15:0]; end
      3'd1: begin p = sa * sb; return p[31:16]; end
      3'd2: begin p = sa * ub; return p[31:16]; end
      3'd3: begin p = ua * ub; return p[31:16]; end
      3'd4: begin
        if (b == 16'h0) return 16'hFFFF;
        if (ovf) return 16'h8000;
        p = sa / sb; return p[15:0];
      end
      3'd5: begin
        if (b == 16'h0) return 16'hFFFF;
        p = ua / ub; return p[15:0];
      end
      3'd6: begin
        if (b == 16'h0) return a;
        if (ovf) return 16'h0000;
        p = sa % sb; return p[15:0];
      end
      default: begin
        if (b == 16'h0) return a;
        p = ua % ub; return p[15:0];
      end
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n, lat;
    logic seen;
    logic [15:0] a16, b16, e16;
    logic [2:0]  o16;

    rst = 1'b1; in_valid = 1'b0; mdu_op = 3'b000; rs1 = 32'h0; rs2 = 32'h0;
    flush = 1'b0; out_ready = 1'b0;
    h_in_valid = 1'b0; h_op = 3'b000; h_rs1 = 16'h0; h_rs2 = 16'h0; h_flush = 1'b0; h_out_ready = 1'b1;
    #1;
    chk("reset_state", {60'h0, in_ready, out_valid, busy, 1'b0}, 64'h8);
    chk("reset_result", {32'h0, mdu_result}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op32(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL32, "mul_7x-3");
    op32(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL32, "mulh_min");
    op32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL32, "mulhu_ones");
    op32(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL32, "mulhsu");
    op32(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV32, "div_-7/2");
    op32(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV32, "rem_-7/2");
    op32(3'b101, 32'd100,      32'd7,        32'd14,       DIV32, "divu_100/7");
    op32(3'b111, 32'd100,      32'd7,        32'd2,        DIV32, "remu_100/7");
    op32(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV32, "div_7/-2");
    op32(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV32, "rem_7/-2");
    op32(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,     "div_by0");
    op32(3'b110, 32'd5,        32'd0,        32'd5,        1,     "rem_by0");
    op32(3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1,     "divu_by0");
    op32(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,     "div_ovf");
    op32(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,     "rem_ovf");

    // Result held in DONE while the consumer stalls
    @(negedge clk);
    in_valid = 1'b1; mdu_op = 3'b011; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = 32'h12345678;
    wait_done32(n);
    chk("hold_lat", 64'(n), 64'(MUL32));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {31'h0, out_valid, in_ready, mdu_result}, {31'h1, 1'b0, 32'hFFFFFFFE});
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; mdu_op = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    chk("release_idle", {61'h0, in_ready, out_valid, busy}, 64'h4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accept", {63'h0, busy}, 64'h1);
    wait_done32(n);
    chk("b2b_lat", 64'(n), 64'(DIV32));
    chk("b2b_res", {32'h0, mdu_result}, 64'd14);
    @(posedge clk); #1;

    // Flush at iteration 10
    @(negedge clk);
    in_valid = 1'b1; mdu_op = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {61'h0, in_ready, busy, out_valid}, 64'h4);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid | busy;
    end
    chk("flush_no_result", {63'h0, seen}, 64'h0);

    // flush beats in_valid in IDLE
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; mdu_op = 3'b101; rs1 = 32'd50; rs2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", {61'h0, in_ready, busy, out_valid}, 64'h4);

    // flush together with out_ready in DONE
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; mdu_op = 3'b100; rs1 = 32'd5; rs2 = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_before_flush", {63'h0, out_valid}, 64'h1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_done", {62'h0, in_ready, out_valid}, 64'h2);

    // Reset mid-BUSY
    @(negedge clk);
    in_valid = 1'b1; mdu_op = 3'b101; rs1 = 32'd777; rs2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", {29'h0, in_ready, busy, out_valid, mdu_result}, {29'h0, 3'b100, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid | busy;
    end
    chk("rst_no_result", {63'h0, seen}, 64'h0);
    op32(3'b111, 32'd100, 32'd7, 32'd2, DIV32, "after_rst");

    // XLEN=16, UNROLL=4 sweep against the reference function
    for (int k = 0; k < 60; k++) begin
      o16 = 3'($urandom);
      a16 = pick16();
      b16 = pick16();
      e16 = ref16(o16, a16, b16);
      if (o16[2] && ((b16 == 16'h0) || (!o16[0] && a16 == 16'h8000 && b16 == 16'hFFFF))) lat = 1;
      else if (!o16[2] && FASTM) lat = 1;
      else lat = 5;
      @(negedge clk);
      h_in_valid = 1'b1; h_op = o16; h_rs1 = a16; h_rs2 = b16;
      @(posedge clk); #1;
      h_in_valid = 1'b0; h_rs1 = 16'($urandom); h_rs2 = 16'($urandom);
      n = 1;
      while (!h_out_valid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("x16_lat op%0d %h %h", o16, a16, b16), 64'(n), 64'(lat));
      chk($sformatf("x16_res op%0d %h %h", o16, a16, b16), {48'h0, h_result}, {48'h0, e16});
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle multiply/divide unit of the RV32IM core.
- Executes all eight RV32M operations iteratively on an XLEN-wide datapath, processing UNROLL bits per cycle.
- Uses valid/ready handshakes on both the request side and the result side, so the core can stall on mdu_ready.
- Sits beside the ALU and feeds the write-back mux mdu input.

Parameters:
- XLEN, 32: operand/result width. Must be even and at least 8.
- UNROLL, 1: bits processed per iteration; must divide XLEN. Iteration count is ITER = XLEN/UNROLL.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- mdu_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A (dividend / multiplicand)
- rs2  in  XLEN  operand B (divisor / multiplier)
- flush  in  1  abort any operation in flight
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- mdu_result  out  XLEN  result
- busy  out  1  high in BUSY or FIX

Behaviour:
- Reset values: in_ready=1, out_valid=0, mdu_result=0, busy=0; FSM goes to IDLE.
- Reset mid-operation discards all state immediately.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch op and operands; go to BUSY with counter=ITER, or to DONE for a special case.
  - BUSY: one UNROLL-bit step per cycle; counter decrements. When counter reaches 1, go to FIX.
  - FIX: sign correction and result select; go to DONE.
  - DONE: out_valid=1 and mdu_result is held stable. On out_ready, go to IDLE.
- Latency: out_valid rises ITER+1 edges after the accepting edge (33 edges for defaults). Special cases take 1 edge.
- Throughput: no new request is accepted in the same cycle a result is taken (in_ready=0 in DONE). One request per ITER+2 cycles when out_ready is held high.
- Multiply:
  - Shift-add on operand magnitudes into a 2*XLEN product.
  - Product is negated in FIX if the operand signs differ; signedness per op (MULHSU: rs1 signed, rs2 unsigned).
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Special cases, resolved at accept:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV returns rs1; REM returns 0.
- Operands are latched at accept; later changes on rs1/rs2/mdu_op are ignored.
- flush:
  - In any state, return to IDLE on the next edge with out_valid=0 and no result produced.
  - flush has priority over in_valid in the same cycle (no accept).
  - flush together with out_ready in DONE still returns to IDLE; the result counts as consumed.
- Results follow RISC-V M semantics exactly for all XLEN.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - The four multiply ops bypass BUSY and compute the 2*XLEN product combinationally at accept.
  - The FSM goes IDLE to DONE, so out_valid rises 1 edge after accept.
  - Divide is unchanged.
- Not defined: multiplies take the iterative path (ITER+1 edges).

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), out_ready=1 -> mdu_result=0xFFFFFFEB; out_valid first high 33 edges after accept (1 edge with MDU_FAST_MUL_EN).
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0. Each result valid 1 edge after accept.
- Hold out_ready=0 for 10 cycles in DONE -> mdu_result stable and in_ready=0. Raise out_ready -> IDLE next edge, then back-to-back request accepted.
- Assert flush at iteration 10, then assert rst mid-BUSY -> out_valid never rises, in_ready=1 next cycle / immediately on rst. Repeat a random sweep with XLEN=16, UNROLL=4 against a reference model.
